// File: rtl/vec_writeback_mem.sv
// vec_writeback_mem
//   Working memory (32 x 16-bit) for the vector unit plus the serial
//   writeback of a VPU result into it, one word per cycle.
//
// Ports
//   clk, rst                   clock / asynchronous active-high reset
//   flat_vec_buffer_wire       VPU result, element j at [16j+15:16j]
//   copy_vec_buffer_flag_wire  writeback request (level, sampled in IDLE)
//   dest_buffer_wire           destination address of element 0
//   length_buffer_wire         element count code (0 means a full buffer)
//   load_en/load_addr/load_data  host word write port, usable in any state
//   flat_memory                registered memory image, word i at [16i+15:16i]
//   busy                       writeback in progress
//   done                       one-cycle pulse after the last word is written
module vec_writeback_mem #(
    parameter int NUM_SIZE        = 16,
    parameter int VEC_BUFFER_LEN  = 8,
    parameter int WORDS_IN_MEMORY = 32,
    localparam int AW = $clog2(WORDS_IN_MEMORY),
    localparam int LW = $clog2(VEC_BUFFER_LEN),
    localparam int CW = LW + 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [VEC_BUFFER_LEN*NUM_SIZE-1:0]    flat_vec_buffer_wire,
    input  logic                                  copy_vec_buffer_flag_wire,
    input  logic [AW-1:0]                         dest_buffer_wire,
    input  logic [LW-1:0]                         length_buffer_wire,
    input  logic                                  load_en,
    input  logic [AW-1:0]                         load_addr,
    input  logic [NUM_SIZE-1:0]                   load_data,
    output logic [WORDS_IN_MEMORY*NUM_SIZE-1:0]   flat_memory,
    output logic                                  busy,
    output logic                                  done
);

    typedef enum logic {IDLE, WRITE} state_t;

    // Snapshot of the request; live inputs are not consulted after capture.
    typedef struct packed {
        logic [VEC_BUFFER_LEN-1:0][NUM_SIZE-1:0] elems;
        logic [AW-1:0]                           dest;
        logic [CW-1:0]                           cnt;
    } req_t;

    state_t  state, state_nxt;
    req_t    req_q;
    logic [CW-1:0] idx;
    logic [WORDS_IN_MEMORY-1:0][NUM_SIZE-1:0] mem;

    logic          cap_en, wr_en, done_nxt, last;
    logic [CW-1:0] cnt_in;
    logic [AW-1:0] wr_addr;
    logic [NUM_SIZE-1:0] wr_data;

    // Length code 0 encodes a full buffer.
    assign cnt_in  = (length_buffer_wire == '0) ? CW'(VEC_BUFFER_LEN)
                                                : CW'(length_buffer_wire);
    // AW-bit add: destination wraps past the top of memory.
    assign wr_addr = req_q.dest + AW'(idx);
    assign wr_data = req_q.elems[idx[LW-1:0]];
    assign last    = (idx == req_q.cnt - CW'(1));

    always_comb begin
        state_nxt = state;
        cap_en    = 1'b0;
        wr_en     = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (copy_vec_buffer_flag_wire) begin
                    cap_en    = 1'b1;
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                wr_en = 1'b1;
                if (last) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            done  <= 1'b0;
            req_q <= '0;
            idx   <= '0;
            mem   <= '0;
        end else begin
            state <= state_nxt;
            done  <= done_nxt;
            if (cap_en) begin
                req_q.elems <= flat_vec_buffer_wire;
                req_q.dest  <= dest_buffer_wire;
                req_q.cnt   <= cnt_in;
                idx         <= '0;
            end else if (wr_en) begin
                idx <= idx + CW'(1);
            end
            // Writeback is assigned last so it wins an address collision.
            if (load_en) mem[load_addr] <= load_data;
            if (wr_en)   mem[wr_addr]   <= wr_data;
        end
    end

    // busy is the WRITE state register itself, so it is registered and
    // mutually exclusive with done (which is only set on leaving WRITE).
    assign busy        = (state == WRITE);
    assign flat_memory = mem;

endmodule

// File: tb/tb_vec_writeback_mem.sv
// Bench for vec_writeback_mem: reset checks, a table of writeback requests,
// hand-written corner sequences and randomized traffic, all compared against
// a queue-based reference model of memory, busy and done.
module tb_vec_writeback_mem;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] vbuf;
    logic         flag;
    logic [4:0]   dest;
    logic [2:0]   len;
    logic         load_en;
    logic [4:0]   load_addr;
    logic [15:0]  load_data;
    logic [511:0] flat_memory;
    logic         busy, done;

    vec_writeback_mem dut (
        .clk                       (clk),
        .rst                       (rst),
        .flat_vec_buffer_wire      (vbuf),
        .copy_vec_buffer_flag_wire (flag),
        .dest_buffer_wire          (dest),
        .length_buffer_wire        (len),
        .load_en                   (load_en),
        .load_addr                 (load_addr),
        .load_data                 (load_data),
        .flat_memory               (flat_memory),
        .busy                      (busy),
        .done                      (done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // ---------------- reference model ----------------
    typedef struct { logic [4:0] a; logic [15:0] d; } wr_t;
    wr_t         q[$];
    logic [15:0] mem_m[32];
    logic        done_m;

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < 32; i++) mem_m[i] = '0;
        done_m = 1'b0;
    endtask

    // One rising edge: pending writes drain one per edge; a new request is
    // only taken when nothing is pending.
    task automatic model_edge();
        int cnt;
        wr_t w;
        if (load_en) mem_m[load_addr] = load_data;
        if (q.size() > 0) begin
            w = q.pop_front();
            mem_m[w.a] = w.d;
            done_m = (q.size() == 0);
        end else begin
            done_m = 1'b0;
            if (flag) begin
                cnt = (len == 0) ? 8 : int'(len);
                for (int j = 0; j < cnt; j++) begin
                    w.a = 5'((int'(dest) + j) % 32);
                    w.d = vbuf[16*j +: 16];
                    q.push_back(w);
                end
            end
        end
    endtask

    function automatic logic [511:0] model_flat();
        logic [511:0] f;
        for (int i = 0; i < 32; i++) f[16*i +: 16] = mem_m[i];
        return f;
    endfunction

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("flat_memory", flat_memory, model_flat());
        chk("busy", 512'(busy), 512'(q.size() != 0));
        chk("done", 512'(done), 512'(done_m));
    endtask

    task automatic set_buf(input logic [15:0] base);
        for (int j = 0; j < 8; j++) vbuf[16*j +: 16] = base + 16'(j);
    endtask

    function automatic logic [15:0] word(input int a);
        return flat_memory[16*a +: 16];
    endfunction

    // Steps until busy falls; returns the number of edges taken.
    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (busy === 1'b1 && cyc < 40) begin
            step();
            cyc++;
        end
        if (cyc >= 40) begin
            n_cmp++; n_err++;
            $display("FAIL wait_idle: busy still high after %0d cycles, required low", cyc);
        end
    endtask

    // ---------------- request table ----------------
    typedef struct {
        logic [4:0]  dest;
        logic [2:0]  len;
        logic [15:0] base;
        int          exp_cycles;
        int          probe_addr;
        logic [15:0] probe_val;
    } vec_t;
    vec_t tbl[6];

    initial begin
        int cyc;
        tbl[0] = '{5'd4,  3'd3, 16'h0001, 3, 6,  16'h0003};
        tbl[1] = '{5'd4,  3'd3, 16'h0001, 3, 7,  16'h0000}; // mem[7] untouched
        tbl[2] = '{5'd30, 3'd0, 16'h0010, 8, 0,  16'h0012}; // wrap, L=0
        tbl[3] = '{5'd31, 3'd1, 16'h0100, 1, 31, 16'h0100};
        tbl[4] = '{5'd0,  3'd7, 16'h0200, 7, 6,  16'h0206};
        tbl[5] = '{5'd28, 3'd5, 16'h00A0, 5, 0,  16'h00A4};

        rst = 1'b1; flag = 0; vbuf = '0; dest = '0; len = '0;
        load_en = 0; load_addr = '0; load_data = '0;
        model_reset();
        @(negedge clk);
        chk("reset flat_memory", flat_memory, '0);
        chk("reset busy", 512'(busy), 512'(0));
        chk("reset done", 512'(done), 512'(0));
        rst = 1'b0;
        step();

        // host load
        load_en = 1; load_addr = 5'd5; load_data = 16'h1234;
        step();
        chk("host load bits[95:80]", 512'(flat_memory[95:80]), 512'(16'h1234));
        load_en = 0;
        step();

        // table-driven requests
        foreach (tbl[i]) begin
            set_buf(tbl[i].base); dest = tbl[i].dest; len = tbl[i].len; flag = 1;
            step();
            flag = 0;
            wait_idle(cyc);
            chk($sformatf("tbl%0d busy cycles", i), 512'(cyc), 512'(tbl[i].exp_cycles));
            chk($sformatf("tbl%0d done pulse", i), 512'(done), 512'(1));
            chk($sformatf("tbl%0d probe", i), 512'(word(tbl[i].probe_addr)), 512'(tbl[i].probe_val));
            step();
        end

        // inputs change during WRITE: captured values are written
        set_buf(16'h0300); dest = 5'd12; len = 3'd4; flag = 1;
        step();
        set_buf(16'h0900); dest = 5'd20;
        wait_idle(cyc);
        for (int k = 0; k < 4; k++)
            chk($sformatf("captured mem[%0d]", 12 + k), 512'(word(12 + k)), 512'(16'h0300 + 16'(k)));
        chk("no accept in done cycle", 512'(busy), 512'(0));
        step();
        chk("accept after done", 512'(busy), 512'(1));
        flag = 0;
        wait_idle(cyc);
        chk("second req mem[23]", 512'(word(23)), 512'(16'h0903));
        step();

        // collision: writeback wins
        vbuf = '0; vbuf[15:0] = 16'hAAAA; dest = 5'd10; len = 3'd1; flag = 1;
        step();
        flag = 0; load_en = 1; load_addr = 5'd10; load_data = 16'h5555;
        step();
        load_en = 0;
        chk("collision mem[10]", 512'(word(10)), 512'(16'hAAAA));
        step();
        // different addresses: both land
        vbuf[15:0] = 16'hBBBB; flag = 1;
        step();
        flag = 0; load_en = 1; load_addr = 5'd20; load_data = 16'h5555;
        step();
        load_en = 0;
        chk("parallel mem[10]", 512'(word(10)), 512'(16'hBBBB));
        chk("parallel mem[20]", 512'(word(20)), 512'(16'h5555));
        step();

        // reset after the 2nd of 5 writes
        set_buf(16'h0400); dest = 5'd0; len = 3'd5; flag = 1;
        step();
        flag = 0;
        step(); step();
        #2 rst = 1'b1;
        #1;
        chk("midreset flat_memory", flat_memory, '0);
        chk("midreset busy", 512'(busy), 512'(0));
        chk("midreset done", 512'(done), 512'(0));
        model_reset();
        @(negedge clk);
        chk("held reset done", 512'(done), 512'(0));
        rst = 1'b0;
        set_buf(16'h0500); dest = 5'd3; len = 3'd2; flag = 1;
        step();
        flag = 0;
        wait_idle(cyc);
        chk("post-reset cycles", 512'(cyc), 512'(2));
        chk("post-reset mem[4]", 512'(word(4)), 512'(16'h0501));
        step();

        // randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            flag      = ($urandom_range(0, 3) == 0);
            dest      = 5'($urandom);
            len       = 3'($urandom);
            for (int j = 0; j < 8; j++) vbuf[16*j +: 16] = 16'($urandom);
            load_en   = $urandom_range(0, 1) == 1;
            load_addr = 5'($urandom);
            load_data = 16'($urandom);
            step();
        end
        flag = 0; load_en = 0;
        wait_idle(cyc);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
